csr_regfile: RTL and testbench
==============================

# csr_regfile

Architectural CSR storage for the single-hart core, directly downstream of the CSR address mapper. It takes the mapper's 5-bit slot index and 64-bit write mask. It performs CSRRW/CSRRS/CSRRC read-modify-writes, runs the free-running mcycle counter, and samples interrupt lines into mip. It also sequences trap entry and mret, producing a registered PC redirect. Reads are combinational; all state updates occur on the clock edge.

## Interface
- HART_ID, default 0, value returned by slot 4 (mhartid)
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- rd_target  in  5  slot index from the mapper, read port
- rdata  out  64  current value of rd_target; unused slots and slot 31 read 0
- req_valid  in  1  CSR write request
- req_ready  out  1  equals !(trap_valid | mret_valid)
- req_target  in  5  slot index from the mapper
- req_mask  in  64  writable-bit mask from the mapper
- req_op  in  2  1=RW, 2=RS, 3=RC; 0 is no-op
- req_wdata  in  64  operand
- req_illegal  out  1  combinational; req_valid and target is 31 or 4 with a non-suppressed write
- trap_valid  in  1  take a trap this cycle
- trap_cause  in  64  value for mcause
- trap_epc  in  64  value for mepc
- trap_tval  in  64  value for mtval
- mret_valid  in  1  execute mret this cycle
- irq_msip, irq_mtip, irq_meip  in  1 each  level interrupt inputs
- redirect_valid  out  1  one-cycle pulse
- redirect_pc  out  64  target PC, valid with redirect_valid
- priv  out  2  current privilege (3=M, 1=S, 0=U)
- satp_o, mstatus_o  out  64 each  registered copies of slots 7 and 0
- irq_pending  out  1  interrupt pending and enabled

## Operation
- Slot map: 0 mstatus/sstatus (shared), 1 mie, 2 mip, 3 mtvec, 4 mhartid, 5 mscratch, 6 mepc, 7 satp, 8 mcause, 9 mcycle, 10 mtval, 11 pmpaddr0, 12 pmpcfg0, 13 medeleg, 14 mideleg, 15 stvec, 17 sscratch, 18 sepc, 19 scause, 20 stval, 21 sie, 22 sip. Slots 16 and 23-30 are not stored: they read 0 and writes are dropped silently.
- Write fires when req_valid & req_ready and op != 0.
  - Computed value: RW gives wdata; RS gives old | wdata; RC gives old & ~wdata.
  - New value is (old & ~mask) | (computed & mask).
  - RS/RC with wdata == 0 is suppressed: no state change and no illegal flag.
  - Writes to slots 4 and 31 are dropped.
- mstatus fields: MIE bit 3, MPIE bit 7, MPP bits 12:11.
- Trap (trap_valid) updates:
  - mepc ← trap_epc, mcause ← trap_cause, mtval ← trap_tval.
  - MPIE ← MIE, MIE ← 0, MPP ← priv, priv ← 3.
  - Redirect to {mtvec[63:2], 2'b00}.
- mret (mret_valid):
  - MIE ← MPIE, MPIE ← 1, priv ← MPP, MPP ← 0.
  - Redirect to mepc, using the mepc value before the edge.
- Priority: trap > mret > CSR write.
  - trap and mret together: only the trap is taken.
  - While trap_valid or mret_valid is high, req_ready is 0 and the request is not consumed.
- mcycle increments by 1 every cycle and wraps from 2^64-1 to 0. A write to slot 9 loads the written value exactly, with no increment that cycle.
- mip bits 3/7/11 are overwritten every cycle from irq_msip/mtip/meip; software writes to those bits are lost. Other mip bits follow the masked write.
- irq_pending = |(mip & mie) & (mstatus.MIE | priv != 3). This is computed from registered state.
- No delegation: medeleg, mideleg, stvec and the S-mode slots are storage only.

## Timing
- Reset (asynchronous, while reset is low):
  - all slots 0, priv = 3, redirect_valid = 0, redirect_pc = 0, satp_o = mstatus_o = 0.
  - irq_pending = 0, and mcycle = 0.
  - Reset asserted mid-trap cancels the redirect pulse immediately.
- rdata and req_illegal are combinational, zero-latency. A read in the same cycle as a write returns the old value; the new value is visible the next cycle.
- Trap/mret at edge N: state is updated at N. redirect_valid is high for exactly cycle N+1, with redirect_pc registered at N.
- Back-to-back traps produce back-to-back single-cycle pulses, each carrying its own target.

## Test plan
- Reset release: rdata of slot 4 = HART_ID, priv = 3. After 10 cycles, slot 9 reads 10; slot 31 reads 0.
- RW to slot 3 with mask 0xFFFF_FFFF_FFFF_FFFC, wdata 0x8000_0003 → slot 3 reads 0x8000_0000 next cycle. RC with wdata 0 → unchanged.
- RS to slot 0 with mask 0x8 (sstatus-style), old 0 → mstatus = 0x8. Then RW 0xFFFF… with mask 0x8 → only bit 3 set.
- Trap from priv 0 with cause 0x8, epc 0x1000, and mtvec 0x2001:
  - mepc = 0x1000, mcause = 8, MPP = 0, MIE = 0, priv = 3.
  - redirect pulse on the following cycle to 0x2000.
- mret after the trap with MPIE = 1 → priv = 0, MIE = 1, one-cycle redirect to 0x1000. trap_valid and mret_valid asserted together → trap only, req_ready = 0.
- mcycle write 0xFFFF_FFFF_FFFF_FFFF → reads that value next cycle, then 0. With irq_mtip = 1, mie = 0x80, MIE = 1 → irq_pending = 1 one cycle after assertion.

Source files
------------

// File: rtl/csr_regfile.sv
// Architectural CSR storage for the single hart: masked CSR read-modify-writes,
// mcycle, interrupt sampling into mip, and trap/mret sequencing with a registered PC redirect.
module csr_regfile #(
  parameter logic [63:0] HART_ID = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_target,
  output logic [63:0] rdata,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_target,
  input  logic [63:0] req_mask,
  input  logic [1:0]  req_op,
  input  logic [63:0] req_wdata,
  output logic        req_illegal,
  input  logic        trap_valid,
  input  logic [63:0] trap_cause,
  input  logic [63:0] trap_epc,
  input  logic [63:0] trap_tval,
  input  logic        mret_valid,
  input  logic        irq_msip,
  input  logic        irq_mtip,
  input  logic        irq_meip,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic [1:0]  priv,
  output logic [63:0] satp_o,
  output logic [63:0] mstatus_o,
  output logic        irq_pending
);

  localparam int NSLOT     = 23;
  localparam int S_MSTATUS = 0;
  localparam int S_MIE     = 1;
  localparam int S_MIP     = 2;
  localparam int S_MTVEC   = 3;
  localparam int S_MEPC    = 6;
  localparam int S_SATP    = 7;
  localparam int S_MCAUSE  = 8;
  localparam int S_MCYCLE  = 9;
  localparam int S_MTVAL   = 10;

  localparam logic [1:0] OP_RW = 2'd1;
  localparam logic [1:0] OP_RS = 2'd2;
  localparam logic [1:0] OP_RC = 2'd3;
  localparam logic [1:0] PRIV_M = 2'd3;

  logic [63:0] regs_q [NSLOT];
  logic [63:0] regs_d [NSLOT];
  logic [1:0]  priv_q, priv_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;

  logic [63:0] old_val;
  logic [63:0] computed;
  logic [63:0] wr_value;
  logic        suppress;
  logic        stored;
  logic        wr_fire;

  // Handshake: a request is consumed on a cycle where req_valid and req_ready are both
  // high; req_ready drops while a trap or mret is presented, and the request must be held.
  assign req_ready = !(trap_valid | mret_valid);

  // Slots 4 (constant hartid), 16 and 23..31 hold no state.
  assign stored   = (req_target <= 5'd22) && (req_target != 5'd4) && (req_target != 5'd16);
  assign suppress = ((req_op == OP_RS) || (req_op == OP_RC)) && (req_wdata == 64'd0);
  assign wr_fire  = req_valid && req_ready && (req_op != 2'd0) && !suppress && stored;

  assign req_illegal = req_valid && ((req_target == 5'd31) || (req_target == 5'd4)) &&
                       (req_op != 2'd0) && !suppress;

  always_comb begin
    rdata   = '0;
    old_val = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (rd_target == 5'(i)) rdata = regs_q[i];
      if (req_target == 5'(i)) old_val = regs_q[i];
    end
    if (rd_target == 5'd4) rdata = HART_ID;
  end

  always_comb begin
    computed = req_wdata;
    case (req_op)
      OP_RW:   computed = req_wdata;
      OP_RS:   computed = old_val | req_wdata;
      OP_RC:   computed = old_val & ~req_wdata;
      default: computed = old_val;
    endcase
  end

  assign wr_value = (old_val & ~req_mask) | (computed & req_mask);

  always_comb begin
    regs_d           = regs_q;
    priv_d           = priv_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    regs_d[S_MCYCLE] = regs_q[S_MCYCLE] + 64'd1;
    for (int i = 0; i < NSLOT; i++) begin
      if (wr_fire && (req_target == 5'(i))) regs_d[i] = wr_value;
    end

    if (trap_valid) begin
      regs_d[S_MEPC]             = trap_epc;
      regs_d[S_MCAUSE]           = trap_cause;
      regs_d[S_MTVAL]            = trap_tval;
      regs_d[S_MSTATUS][7]       = regs_q[S_MSTATUS][3];
      regs_d[S_MSTATUS][3]       = 1'b0;
      regs_d[S_MSTATUS][12:11]   = priv_q;
      priv_d                     = PRIV_M;
      redirect_valid_d           = 1'b1;
      redirect_pc_d              = {regs_q[S_MTVEC][63:2], 2'b00};
    end else if (mret_valid) begin
      regs_d[S_MSTATUS][3]       = regs_q[S_MSTATUS][7];
      regs_d[S_MSTATUS][7]       = 1'b1;
      regs_d[S_MSTATUS][12:11]   = 2'b00;
      priv_d                     = regs_q[S_MSTATUS][12:11];
      redirect_valid_d           = 1'b1;
      redirect_pc_d              = regs_q[S_MEPC];
    end

    // Hardware-owned pending bits win over any software write in the same cycle.
    regs_d[S_MIP][3]  = irq_msip;
    regs_d[S_MIP][7]  = irq_mtip;
    regs_d[S_MIP][11] = irq_meip;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSLOT; i++) regs_q[i] <= '0;
      priv_q           <= PRIV_M;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) regs_q[i] <= regs_d[i];
      priv_q           <= priv_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign priv           = priv_q;
  assign satp_o         = regs_q[S_SATP];
  assign mstatus_o      = regs_q[S_MSTATUS];
  assign irq_pending    = (|(regs_q[S_MIP] & regs_q[S_MIE])) &&
                          (regs_q[S_MSTATUS][3] || (priv_q != PRIV_M));

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: CSR read-modify-write, traps/mret,
// redirects, mcycle and interrupt pending, with an expected-value queue.
module tb_csr_regfile;

  localparam logic [63:0] HART = 64'h0000_0000_0000_0005;
  localparam logic [63:0] ALL  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        reset;
  logic [4:0]  rd_target;
  logic [63:0] rdata;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_target;
  logic [63:0] req_mask;
  logic [1:0]  req_op;
  logic [63:0] req_wdata;
  logic        req_illegal;
  logic        trap_valid;
  logic [63:0] trap_cause;
  logic [63:0] trap_epc;
  logic [63:0] trap_tval;
  logic        mret_valid;
  logic        irq_msip;
  logic        irq_mtip;
  logic        irq_meip;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [1:0]  priv;
  logic [63:0] satp_o;
  logic [63:0] mstatus_o;
  logic        irq_pending;

  logic [63:0] exp_q[$];
  logic [63:0] exp;
  int vectors;
  int miscompares;

  csr_regfile #(.HART_ID(HART)) dut (
    .clk(clk), .reset(reset),
    .rd_target(rd_target), .rdata(rdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_target(req_target),
    .req_mask(req_mask), .req_op(req_op), .req_wdata(req_wdata), .req_illegal(req_illegal),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
    .mret_valid(mret_valid),
    .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .priv(priv), .satp_o(satp_o), .mstatus_o(mstatus_o), .irq_pending(irq_pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic idle_inputs();
    req_valid  = 1'b0;
    req_target = '0;
    req_mask   = '0;
    req_op     = '0;
    req_wdata  = '0;
    trap_valid = 1'b0;
    trap_cause = '0;
    trap_epc   = '0;
    trap_tval  = '0;
    mret_valid = 1'b0;
    irq_msip   = 1'b0;
    irq_mtip   = 1'b0;
    irq_meip   = 1'b0;
    rd_target  = '0;
  endtask

  task automatic drive_req(input logic [4:0] t, input logic [63:0] m,
                           input logic [1:0] op, input logic [63:0] wd);
    req_valid  = 1'b1;
    req_target = t;
    req_mask   = m;
    req_op     = op;
    req_wdata  = wd;
  endtask

  task automatic do_write(input logic [4:0] t, input logic [63:0] m,
                          input logic [1:0] op, input logic [63:0] wd);
    @(negedge clk);
    drive_req(t, m, op, wd);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 2'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    rd_target = 5'd9;
    #1;
    vectors++;
    if (rdata !== 64'd0) begin miscompares++; $display("FAIL reset_mcycle: got %h want 0", rdata); end
    vectors++;
    if (priv !== 2'd3) begin miscompares++; $display("FAIL reset_priv: got %0d want 3", priv); end
    vectors++;
    if (redirect_valid !== 1'b0 || irq_pending !== 1'b0 || mstatus_o !== 64'd0 || satp_o !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: redirect_valid=%b irq_pending=%b mstatus=%h satp=%h want all 0",
               redirect_valid, irq_pending, mstatus_o, satp_o);
    end
    reset = 1'b1;
    repeat (10) @(negedge clk);
    exp_q.push_back(64'd10);
    rd_target = 5'd9;
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp) begin miscompares++; $display("FAIL mcycle_after_10: got %h want %h", rdata, exp); end
    rd_target = 5'd4;
    #1;
    vectors++;
    if (rdata !== HART) begin miscompares++; $display("FAIL mhartid: got %h want %h", rdata, HART); end
    rd_target = 5'd31;
    #1;
    vectors++;
    if (rdata !== 64'd0) begin miscompares++; $display("FAIL slot31_read: got %h want 0", rdata); end
  endtask

  task automatic test_csr_rw();
    @(negedge clk);
    drive_req(5'd3, 64'hFFFF_FFFF_FFFF_FFFC, 2'd1, 64'h8000_0003);
    rd_target = 5'd3;
    #1;
    vectors++;
    if (rdata !== 64'd0) begin miscompares++; $display("FAIL same_cycle_old: got %h want 0", rdata); end
    exp_q.push_back(64'h8000_0000);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp) begin miscompares++; $display("FAIL mtvec_rw: got %h want %h", rdata, exp); end

    exp_q.push_back(64'h8000_0000);
    do_write(5'd3, ALL, 2'd3, 64'd0);
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp) begin miscompares++; $display("FAIL rc_zero_suppress: got %h want %h", rdata, exp); end

    exp_q.push_back(64'h8000_0000);
    do_write(5'd3, ALL, 2'd0, 64'h1234);
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp) begin miscompares++; $display("FAIL op0_noop: got %h want %h", rdata, exp); end

    exp_q.push_back(64'h8);
    do_write(5'd0, 64'h8, 2'd2, 64'h8);
    rd_target = 5'd0;
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp || mstatus_o !== exp) begin
      miscompares++;
      $display("FAIL sstatus_rs: rdata %h mstatus_o %h want %h", rdata, mstatus_o, exp);
    end

    exp_q.push_back(64'h8);
    do_write(5'd0, 64'h8, 2'd1, ALL);
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (mstatus_o !== exp) begin miscompares++; $display("FAIL sstatus_rw_mask: got %h want %h", mstatus_o, exp); end

    exp_q.push_back(64'h0000_0000_DEAD_B000);
    do_write(5'd7, ALL, 2'd1, 64'h0000_0000_DEAD_B000);
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (satp_o !== exp) begin miscompares++; $display("FAIL satp_o: got %h want %h", satp_o, exp); end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    drive_req(5'd4, ALL, 2'd1, ALL);
    #1;
    vectors++;
    if (req_illegal !== 1'b1) begin miscompares++; $display("FAIL illegal_hartid: got %b want 1", req_illegal); end
    drive_req(5'd31, ALL, 2'd2, 64'd0);
    #1;
    vectors++;
    if (req_illegal !== 1'b0) begin miscompares++; $display("FAIL illegal_suppressed: got %b want 0", req_illegal); end
    drive_req(5'd31, ALL, 2'd3, 64'd1);
    #1;
    vectors++;
    if (req_illegal !== 1'b1) begin miscompares++; $display("FAIL illegal_slot31: got %b want 1", req_illegal); end
    drive_req(5'd16, ALL, 2'd1, ALL);
    #1;
    vectors++;
    if (req_illegal !== 1'b0) begin miscompares++; $display("FAIL illegal_slot16: got %b want 0", req_illegal); end
    @(negedge clk);
    req_valid = 1'b0;
    rd_target = 5'd16;
    #1;
    vectors++;
    if (rdata !== 64'd0) begin miscompares++; $display("FAIL slot16_dropped: got %h want 0", rdata); end
    rd_target = 5'd4;
    #1;
    vectors++;
    if (rdata !== HART) begin miscompares++; $display("FAIL hartid_kept: got %h want %h", rdata, HART); end
  endtask

  task automatic test_mip();
    exp_q.push_back(64'hFFFF_FFFF_FFFF_F777);
    do_write(5'd2, ALL, 2'd1, ALL);
    rd_target = 5'd2;
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp) begin miscompares++; $display("FAIL mip_hw_bits: got %h want %h", rdata, exp); end
    exp_q.push_back(64'd0);
    do_write(5'd2, ALL, 2'd1, 64'd0);
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp) begin miscompares++; $display("FAIL mip_clear: got %h want %h", rdata, exp); end
  endtask

  task automatic test_trap_mret();
    do_write(5'd6, ALL, 2'd1, 64'h500);
    do_write(5'd3, ALL, 2'd1, 64'h2001);
    // mret from M with MPP=0 drops to U
    @(negedge clk);
    mret_valid = 1'b1;
    exp_q.push_back(64'h500);
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL ready_during_mret: got %b want 0", req_ready); end
    @(negedge clk);
    mret_valid = 1'b0;
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (redirect_valid !== 1'b1 || redirect_pc !== exp) begin
      miscompares++;
      $display("FAIL mret_setup_redirect: valid %b pc %h want 1 %h", redirect_valid, redirect_pc, exp);
    end
    vectors++;
    if (priv !== 2'd0 || mstatus_o !== 64'h80) begin
      miscompares++;
      $display("FAIL mret_setup_state: priv %0d mstatus %h want 0 80", priv, mstatus_o);
    end
    do_write(5'd0, ALL, 2'd2, 64'h8);
    #1;
    vectors++;
    if (redirect_valid !== 1'b0 || mstatus_o !== 64'h88) begin
      miscompares++;
      $display("FAIL pulse_end_mie_set: valid %b mstatus %h want 0 88", redirect_valid, mstatus_o);
    end

    @(negedge clk);
    trap_valid = 1'b1;
    trap_cause = 64'h8;
    trap_epc   = 64'h1000;
    trap_tval  = 64'h33;
    exp_q.push_back(64'h2000);
    @(negedge clk);
    trap_valid = 1'b0;
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (redirect_valid !== 1'b1 || redirect_pc !== exp) begin
      miscompares++;
      $display("FAIL trap_redirect: valid %b pc %h want 1 %h", redirect_valid, redirect_pc, exp);
    end
    vectors++;
    if (priv !== 2'd3 || mstatus_o !== 64'h80) begin
      miscompares++;
      $display("FAIL trap_status: priv %0d mstatus %h want 3 80", priv, mstatus_o);
    end
    rd_target = 5'd6;
    #1;
    vectors++;
    if (rdata !== 64'h1000) begin miscompares++; $display("FAIL trap_mepc: got %h want 1000", rdata); end
    rd_target = 5'd8;
    #1;
    vectors++;
    if (rdata !== 64'h8) begin miscompares++; $display("FAIL trap_mcause: got %h want 8", rdata); end
    rd_target = 5'd10;
    #1;
    vectors++;
    if (rdata !== 64'h33) begin miscompares++; $display("FAIL trap_mtval: got %h want 33", rdata); end
    @(negedge clk);
    #1;
    vectors++;
    if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL trap_pulse_width: got %b want 0", redirect_valid); end

    @(negedge clk);
    mret_valid = 1'b1;
    exp_q.push_back(64'h1000);
    @(negedge clk);
    mret_valid = 1'b0;
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (redirect_valid !== 1'b1 || redirect_pc !== exp) begin
      miscompares++;
      $display("FAIL mret_redirect: valid %b pc %h want 1 %h", redirect_valid, redirect_pc, exp);
    end
    vectors++;
    if (priv !== 2'd0 || mstatus_o !== 64'h88) begin
      miscompares++;
      $display("FAIL mret_status: priv %0d mstatus %h want 0 88", priv, mstatus_o);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL mret_pulse_width: got %b want 0", redirect_valid); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    trap_valid = 1'b1;
    trap_cause = 64'h2;
    trap_epc   = 64'h3000;
    trap_tval  = 64'h0;
    mret_valid = 1'b1;
    drive_req(5'd5, ALL, 2'd1, 64'hAB);
    exp_q.push_back(64'h2000);
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL ready_trap_mret: got %b want 0", req_ready); end
    @(negedge clk);
    trap_valid = 1'b0;
    mret_valid = 1'b0;
    rd_target  = 5'd5;
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (redirect_valid !== 1'b1 || redirect_pc !== exp) begin
      miscompares++;
      $display("FAIL priority_redirect: valid %b pc %h want 1 %h", redirect_valid, redirect_pc, exp);
    end
    vectors++;
    if (priv !== 2'd3 || mstatus_o !== 64'h80 || rdata !== 64'd0) begin
      miscompares++;
      $display("FAIL priority_state: priv %0d mstatus %h slot5 %h want 3 80 0", priv, mstatus_o, rdata);
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    vectors++;
    if (rdata !== 64'hAB) begin miscompares++; $display("FAIL held_request: got %h want ab", rdata); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    trap_valid = 1'b1;
    trap_epc   = 64'h4000;
    trap_cause = 64'h3;
    exp_q.push_back(64'h2000);
    @(negedge clk);
    trap_valid = 1'b0;
    mret_valid = 1'b1;
    exp_q.push_back(64'h4000);
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (redirect_valid !== 1'b1 || redirect_pc !== exp) begin
      miscompares++;
      $display("FAIL b2b_first: valid %b pc %h want 1 %h", redirect_valid, redirect_pc, exp);
    end
    @(negedge clk);
    mret_valid = 1'b0;
    trap_valid = 1'b1;
    trap_epc   = 64'h5000;
    exp_q.push_back(64'h2000);
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (redirect_valid !== 1'b1 || redirect_pc !== exp) begin
      miscompares++;
      $display("FAIL b2b_second: valid %b pc %h want 1 %h", redirect_valid, redirect_pc, exp);
    end
    @(negedge clk);
    trap_valid = 1'b0;
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (redirect_valid !== 1'b1 || redirect_pc !== exp) begin
      miscompares++;
      $display("FAIL b2b_third: valid %b pc %h want 1 %h", redirect_valid, redirect_pc, exp);
    end
    @(negedge clk);
    rd_target = 5'd6;
    #1;
    vectors++;
    if (redirect_valid !== 1'b0 || priv !== 2'd3 || mstatus_o !== 64'h1800 || rdata !== 64'h5000) begin
      miscompares++;
      $display("FAIL b2b_final: valid %b priv %0d mstatus %h mepc %h want 0 3 1800 5000",
               redirect_valid, priv, mstatus_o, rdata);
    end
  endtask

  task automatic test_mcycle();
    exp_q.push_back(ALL);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd1);
    do_write(5'd9, ALL, 2'd1, ALL);
    rd_target = 5'd9;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      exp = exp_q.pop_front();
      vectors++;
      if (rdata !== exp) begin miscompares++; $display("FAIL mcycle_wrap_%0d: got %h want %h", i, rdata, exp); end
    end
  endtask

  task automatic test_irq();
    do_write(5'd1, ALL, 2'd1, 64'h80);
    do_write(5'd0, ALL, 2'd2, 64'h8);
    #1;
    vectors++;
    if (irq_pending !== 1'b0) begin miscompares++; $display("FAIL irq_idle: got %b want 0", irq_pending); end
    @(negedge clk);
    irq_mtip = 1'b1;
    #1;
    vectors++;
    if (irq_pending !== 1'b0) begin miscompares++; $display("FAIL irq_same_cycle: got %b want 0", irq_pending); end
    @(negedge clk);
    rd_target = 5'd2;
    #1;
    vectors++;
    if (irq_pending !== 1'b1 || rdata !== 64'h80) begin
      miscompares++;
      $display("FAIL irq_pending: pending %b mip %h want 1 80", irq_pending, rdata);
    end
    do_write(5'd0, ALL, 2'd3, 64'h8);
    #1;
    vectors++;
    if (irq_pending !== 1'b0) begin miscompares++; $display("FAIL irq_masked_mie: got %b want 0", irq_pending); end
  endtask

  task automatic test_reset_mid_trap();
    @(negedge clk);
    trap_valid = 1'b1;
    trap_epc   = 64'h6000;
    @(posedge clk);
    #2;
    trap_valid = 1'b0;
    #1;
    vectors++;
    if (redirect_valid !== 1'b1) begin miscompares++; $display("FAIL pre_reset_pulse: got %b want 1", redirect_valid); end
    reset     = 1'b0;
    irq_mtip  = 1'b0;
    rd_target = 5'd9;
    #1;
    vectors++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 64'd0 || priv !== 2'd3 || mstatus_o !== 64'd0 ||
        irq_pending !== 1'b0 || rdata !== 64'd0) begin
      miscompares++;
      $display("FAIL async_reset: valid %b pc %h priv %0d mstatus %h pending %b mcycle %h",
               redirect_valid, redirect_pc, priv, mstatus_o, irq_pending, rdata);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle_inputs();
    test_reset();
    test_csr_rw();
    test_illegal();
    test_mip();
    test_trap_mret();
    test_priority();
    test_back_to_back();
    test_mcycle();
    test_irq();
    test_reset_mid_trap();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
